vga_sync_timing_detector_640x480_60hz: RTL
==========================================

// Module: vga_sync_timing_detector_640x480_60hz
// PURPOSE
//  Receive side of the 640x480@60Hz VGA sync interface.
//  - Watches HSYNC/VSYNC/BLANK (active-low syncs, active-high blank) coming from a timing generator.
//  - Checks line/frame periods against nominal values and declares lock.
//  - Recovers active-pixel X/Y coordinates for downstream capture/overlay logic in the vga_sdram path.
// PARAMETERS
//  P_H_TOTAL     800  nominal clocks per line (HSYNC fall to HSYNC fall)
//  P_H_TOL       2    allowed +/- deviation of measured line length, clocks
//  P_V_TOTAL     525  nominal lines per frame (VSYNC fall to VSYNC fall)
//  P_LOCK_FRAMES 2    consecutive good frames required to enter LOCKED (1..15)
// PORTS
//  iVGA_CLOCK     in   1   pixel clock, 25.2MHz
//  inRESET        in   1   asynchronous active-low reset
//  iRESET_SYNC    in   1   synchronous clear of all state, same effect as reset
//  iDISP_HSYNC    in   1   active-low hsync, synchronous to iVGA_CLOCK
//  iDISP_VSYNC    in   1   active-low vsync, synchronous to iVGA_CLOCK
//  iDISP_BLANK    in   1   1=blanking, 0=active pixel
//  oLOCKED        out  1   timing locked to nominal 640x480
//  oPIXEL_VALID   out  1   current coordinate is an active pixel (locked only)
//  oPIXEL_X       out  10  active pixel column 0..639
//  oPIXEL_Y       out  9   active pixel row 0..479
//  oFRAME_START   out  1   1-cycle pulse at each frame boundary while locked
//  oTIMING_ERROR  out  1   1-cycle pulse on any period violation
// BEHAVIOUR
//  - Reset (async inRESET low, or iRESET_SYNC high at a clock edge): every output is 0, state UNLOCK, all counters 0.
//  - Edge detect: previous-value registers on HSYNC/VSYNC. A fall is prev=1 & cur=0.
//    Previous-value registers reset to 1.
//  - h_len: 11 bits. Clears to 1 on an HSYNC fall, else +1. Saturates at 2047.
//    - At an HSYNC fall, the line is good iff the pre-clear h_len is in [P_H_TOTAL-P_H_TOL, P_H_TOTAL+P_H_TOL].
//    - The first HSYNC fall after reset or UNLOCK is not checked.
//  - v_len: 10 bits. +1 on each HSYNC fall, clears to 0 on a VSYNC fall.
//    - At a VSYNC fall, the frame is good iff v_len == P_V_TOTAL and no bad line occurred since the previous VSYNC fall.
//    - When HSYNC and VSYNC fall in the same cycle, the HSYNC check and v_len increment apply before the VSYNC check.
//  - State machine, 2-bit:
//    - UNLOCK -> ACQUIRE on the first VSYNC fall. good_cnt=0.
//    - ACQUIRE:
//      - On a good frame, good_cnt+1. LOCKED when good_cnt reaches P_LOCK_FRAMES.
//      - On a bad line or bad frame, good_cnt=0 and stay in ACQUIRE.
//    - LOCKED -> UNLOCK on any bad line, bad frame, or h_len reaching 2047 (sync loss).
//    - Sync loss (h_len saturated) in any state -> UNLOCK.
//  - oTIMING_ERROR: pulses the cycle after a bad-line/bad-frame/sync-loss detection in ACQUIRE or LOCKED.
//    Sync loss pulses once, not every saturated cycle.
//  - oLOCKED: registered. Rises 1 cycle after the qualifying VSYNC fall. Falls 1 cycle after the error.
//  - Coordinates, registered, 1-cycle latency from the BLANK input:
//    - x_cnt clears on an HSYNC fall, +1 per cycle with BLANK=0.
//    - Row counter +1 at the first BLANK 1->0 transition of each line. It clears on a VSYNC fall.
//    - oPIXEL_X/Y hold the current pixel's index. oPIXEL_VALID = LOCKED & !BLANK & x<640 & y<480.
//    - Pixels beyond 639/479 are counted as valid=0, with X/Y frozen at their last value.
//  - oFRAME_START: pulses 1 cycle after a VSYNC fall only while oLOCKED is already 1 (not on the locking edge).
//  - Lock loss mid-frame: oPIXEL_VALID drops in the same cycle as oLOCKED. Counters keep running.
// CONFIGURATION
//  VGA_SYNC_DET_ERRCNT_EN defined:
//    - Adds output oERROR_COUNT [15:0].
//    - +1 per oTIMING_ERROR pulse, saturates at 16'hFFFF, cleared by reset/iRESET_SYNC.
//  Not defined: the port and counter are absent. All other behaviour is identical.
// TESTING
//  1. Nominal 800x525 timing, syncs 96 clk / 2 lines, active from clock 144 of each line and line 35 of each frame
//     -> oLOCKED=1 one clock after the 3rd VSYNC fall (P_LOCK_FRAMES=2); no oTIMING_ERROR.
//  2. Locked, then one line of 805 clocks -> oTIMING_ERROR pulse 1 clk after that HSYNC fall; oLOCKED=0, oPIXEL_VALID=0.
//  3. Locked frame -> first valid pixel X=0,Y=0; last X=639,Y=479; exactly 307200 oPIXEL_VALID cycles; one oFRAME_START per frame.
//  4. Line length 798 and 802 (tolerance edges) -> lock kept; 797 -> error and unlock.
//  5. Frame of 524 lines while locked -> error at VSYNC fall, UNLOCK; relock after 2 further good frames.
//  6. HSYNC held high 2048+ clocks while locked -> single error pulse, UNLOCK; assert inRESET mid-frame -> all outputs 0 at once.
//     With ERRCNT_EN, oERROR_COUNT increments per scenario error.

Source files
------------

// File: rtl/vga_sync_timing_detector_640x480_60hz.sv
// Receive-side 640x480@60Hz sync checker: validates line/frame periods, declares lock, recovers pixel X/Y.
// Define VGA_SYNC_DET_ERRCNT_EN to add the saturating oERROR_COUNT output.
module vga_sync_timing_detector_640x480_60hz #(
    parameter int P_H_TOTAL     = 800,
    parameter int P_H_TOL       = 2,
    parameter int P_V_TOTAL     = 525,
    parameter int P_LOCK_FRAMES = 2,
    parameter int P_H_ACTIVE    = 640,
    parameter int P_V_ACTIVE    = 480
) (
    input  logic        iVGA_CLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    input  logic        iDISP_HSYNC,
    input  logic        iDISP_VSYNC,
    input  logic        iDISP_BLANK,
    output logic        oLOCKED,
    output logic        oPIXEL_VALID,
    output logic [9:0]  oPIXEL_X,
    output logic [8:0]  oPIXEL_Y,
    output logic        oFRAME_START,
    output logic        oTIMING_ERROR
`ifdef VGA_SYNC_DET_ERRCNT_EN
    ,
    output logic [15:0] oERROR_COUNT
`endif
);
    localparam logic [1:0]  S_UNLOCK  = 2'd0;
    localparam logic [1:0]  S_ACQUIRE = 2'd1;
    localparam logic [1:0]  S_LOCKED  = 2'd2;
    localparam logic [10:0] H_MIN     = 11'(P_H_TOTAL - P_H_TOL);
    localparam logic [10:0] H_MAX     = 11'(P_H_TOTAL + P_H_TOL);
    localparam logic [9:0]  V_NOM     = 10'(P_V_TOTAL);
    localparam logic [3:0]  LOCK_N    = 4'(P_LOCK_FRAMES);
    localparam logic [9:0]  X_LIM     = 10'(P_H_ACTIVE);
    localparam logic [9:0]  Y_LIM     = 10'(P_V_ACTIVE);

    logic        r_hs_prev, r_vs_prev, r_blank_prev;
    logic [10:0] r_h_len;
    logic        r_h_armed, r_sat_q, r_line_bad_seen;
    logic [9:0]  r_v_len;
    logic [1:0]  r_state, w_state_nxt;
    logic [3:0]  r_good_cnt, w_good_nxt, w_good_inc;
    logic [9:0]  r_x_cnt, r_y_cnt;
    logic        r_row_seen;

    logic        w_hfall, w_vfall, w_h_sat, w_sync_loss, w_line_bad, w_frame_bad, w_err;
    logic [9:0]  w_v_next, w_x_cur, w_y_base, w_y_cur;
    logic        w_row_seen, w_row_start, w_in_range;

    assign w_hfall     = r_hs_prev & ~iDISP_HSYNC;
    assign w_vfall     = r_vs_prev & ~iDISP_VSYNC;
    assign w_h_sat     = (r_h_len == 11'h7FF);
    assign w_sync_loss = w_h_sat & ~r_sat_q;
    assign w_line_bad  = w_hfall & r_h_armed & ((r_h_len < H_MIN) | (r_h_len > H_MAX));
    // The line count includes an HSYNC fall coincident with the VSYNC fall.
    assign w_v_next    = r_v_len + 10'(w_hfall);
    assign w_frame_bad = w_vfall & ((w_v_next != V_NOM) | r_line_bad_seen | w_line_bad);
    assign w_err       = (r_state == S_ACQUIRE || r_state == S_LOCKED)
                         & (w_line_bad | w_frame_bad | w_sync_loss);
    assign w_good_inc  = r_good_cnt + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        case (r_state)
            S_UNLOCK: begin
                if (w_vfall && !(w_h_sat && !w_hfall)) begin
                    w_state_nxt = S_ACQUIRE;
                    w_good_nxt  = '0;
                end
            end
            S_ACQUIRE: begin
                if (w_sync_loss)
                    w_state_nxt = S_UNLOCK;
                else if (w_line_bad || w_frame_bad)
                    w_good_nxt = '0;
                else if (w_vfall) begin
                    w_good_nxt = w_good_inc;
                    if (w_good_inc >= LOCK_N)
                        w_state_nxt = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (w_err)
                    w_state_nxt = S_UNLOCK;
            end
            default: w_state_nxt = S_UNLOCK;
        endcase
    end

    // Row index advances on the first active pixel of a line; Y of later pixels is one behind the count.
    assign w_x_cur     = w_hfall ? 10'd0 : r_x_cnt;
    assign w_row_seen  = w_hfall ? 1'b0 : r_row_seen;
    assign w_row_start = ~iDISP_BLANK & r_blank_prev & ~w_row_seen;
    assign w_y_base    = w_vfall ? 10'd0 : r_y_cnt;
    assign w_y_cur     = w_row_start ? w_y_base : w_y_base - 10'd1;
    assign w_in_range  = ~iDISP_BLANK & (w_x_cur < X_LIM) & (w_y_cur < Y_LIM);

    always_ff @(posedge iVGA_CLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_hs_prev <= 1'b1; r_vs_prev <= 1'b1; r_blank_prev <= 1'b1;
            r_h_len <= '0; r_h_armed <= 1'b0; r_sat_q <= 1'b0; r_line_bad_seen <= 1'b0;
            r_v_len <= '0; r_state <= S_UNLOCK; r_good_cnt <= '0;
            r_x_cnt <= '0; r_y_cnt <= '0; r_row_seen <= 1'b0;
            oLOCKED <= 1'b0; oPIXEL_VALID <= 1'b0; oPIXEL_X <= '0; oPIXEL_Y <= '0;
            oFRAME_START <= 1'b0; oTIMING_ERROR <= 1'b0;
        end else if (iRESET_SYNC) begin
            r_hs_prev <= 1'b1; r_vs_prev <= 1'b1; r_blank_prev <= 1'b1;
            r_h_len <= '0; r_h_armed <= 1'b0; r_sat_q <= 1'b0; r_line_bad_seen <= 1'b0;
            r_v_len <= '0; r_state <= S_UNLOCK; r_good_cnt <= '0;
            r_x_cnt <= '0; r_y_cnt <= '0; r_row_seen <= 1'b0;
            oLOCKED <= 1'b0; oPIXEL_VALID <= 1'b0; oPIXEL_X <= '0; oPIXEL_Y <= '0;
            oFRAME_START <= 1'b0; oTIMING_ERROR <= 1'b0;
        end else begin
            r_hs_prev    <= iDISP_HSYNC;
            r_vs_prev    <= iDISP_VSYNC;
            r_blank_prev <= iDISP_BLANK;
            if (w_hfall)       r_h_len <= 11'd1;
            else if (!w_h_sat) r_h_len <= r_h_len + 11'd1;
            r_sat_q <= w_h_sat;
            // Disarming on lock loss leaves the next (arbitrary-length) line unchecked.
            if (r_state != S_UNLOCK && w_state_nxt == S_UNLOCK) r_h_armed <= 1'b0;
            else if (w_hfall)                                  r_h_armed <= 1'b1;
            if (w_vfall)         r_line_bad_seen <= 1'b0;
            else if (w_line_bad) r_line_bad_seen <= 1'b1;
            r_v_len    <= w_vfall ? 10'd0 : w_v_next;
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_nxt;

            if (!iDISP_BLANK) r_x_cnt <= (w_x_cur == 10'h3FF) ? w_x_cur : w_x_cur + 10'd1;
            else              r_x_cnt <= w_x_cur;
            r_row_seen <= w_row_seen | w_row_start;
            if (w_row_start) r_y_cnt <= (w_y_base == 10'h3FF) ? w_y_base : w_y_base + 10'd1;
            else             r_y_cnt <= w_y_base;

            oLOCKED       <= (w_state_nxt == S_LOCKED);
            oPIXEL_VALID  <= (w_state_nxt == S_LOCKED) & w_in_range;
            if (w_in_range) begin
                oPIXEL_X <= w_x_cur;
                oPIXEL_Y <= w_y_cur[8:0];
            end
            oFRAME_START  <= w_vfall & (r_state == S_LOCKED) & (w_state_nxt == S_LOCKED);
            oTIMING_ERROR <= w_err;
        end
    end

`ifdef VGA_SYNC_DET_ERRCNT_EN
    always_ff @(posedge iVGA_CLOCK or negedge inRESET) begin
        if (!inRESET)
            oERROR_COUNT <= '0;
        else if (iRESET_SYNC)
            oERROR_COUNT <= '0;
        else if (w_err && oERROR_COUNT != 16'hFFFF)
            oERROR_COUNT <= oERROR_COUNT + 16'd1;
    end
`endif

endmodule
